// File: rtl/toy_dmem_responder.sv
// ============================================================================
// toy_dmem_responder
// ----------------------------------------------------------------------------
// Data-memory slave for the RISC_TOY core data interface. Holds 2**AW 32-bit
// words with one access per cycle. Reads are registered, so data appears the
// cycle after the request edge. Writes commit at the request edge.
// After reset the whole array is cleared by hardware, one word per cycle,
// while BUSY is high. ERR is a sticky flag that records two conditions:
// a request issued while BUSY, or an out-of-range address.
//
// Optional build macro: DMEM_STATS_EN
//   defined   -> RD_CNT / WR_CNT count accepted in-range reads / writes and
//                saturate at 16'hFFFF.
//   undefined -> both counters are tied to 0 and no counter flops exist.
//
// Parameters:
//   AW      index width; DADDR[AW-1:0] selects the word (AW < 30)
//
// Ports:
//   CLK     in   clock, rising-edge active
//   RSTN    in   asynchronous active-low reset
//   DREQ    in   access request
//   DRW     in   1 = write, 0 = read
//   DADDR   in   30-bit word address
//   DWDATA  in   write data
//   DRDATA  out  registered read data (holds when no read is accepted)
//   BUSY    out  post-reset clear in progress
//   ERR     out  sticky protocol / range error
//   RD_CNT  out  accepted in-range reads
//   WR_CNT  out  accepted in-range writes
// ============================================================================
module toy_dmem_responder #(
  parameter int AW = 10
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        BUSY,
  output logic        ERR,
  output logic [15:0] RD_CNT,
  output logic [15:0] WR_CNT
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          in_range;
  logic          ready;
  logic          rd_ok;
  logic          wr_ok;
  logic          rd_oor;
  logic          req_err;

  assign idx      = DADDR[AW-1:0];
  assign in_range = (DADDR[29:AW] == '0);
  assign ready    = (state_q == READY);

  // Accepted accesses are only possible once the clear has finished.
  assign rd_ok    = ready & DREQ & ~DRW &  in_range;
  assign wr_ok    = ready & DREQ &  DRW &  in_range;
  assign rd_oor   = ready & DREQ & ~DRW & ~in_range;
  assign req_err  = DREQ & (~ready | ~in_range);

  // BUSY means "still clearing". It follows the state register directly,
  // so an asynchronous reset raises it immediately.
  assign BUSY = ~ready;

  // --------------------------------------------------------------------------
  // FSM: state register and clear pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        ptr_q <= ptr_q + AW'(1);
      end
    end
  end

  // Leave INIT on the same edge that clears the last word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (ptr_q == {AW{1'b1}}) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage array. It is not reset directly; the clear sweep in INIT zeroes
  // it. A write is visible to a read issued on the following cycle because
  // the read samples the array after this edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (state_q == INIT) begin
      mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      mem[idx] <= DWDATA;
    end
  end

  // --------------------------------------------------------------------------
  // Read data register and sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DRDATA <= '0;
    end else if (rd_ok) begin
      DRDATA <= mem[idx];
    end else if (rd_oor) begin
      DRDATA <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ERR <= 1'b0;
    end else if (req_err) begin
      ERR <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional access statistics
  // --------------------------------------------------------------------------
`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_ok && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_ok && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign RD_CNT = rd_cnt_q;
  assign WR_CNT = wr_cnt_q;
`else
  assign RD_CNT = 16'h0000;
  assign WR_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_toy_dmem_responder.sv
// ============================================================================
// tb_toy_dmem_responder
// ----------------------------------------------------------------------------
// Self-checking bench for toy_dmem_responder with AW=4 (16 words).
// The reference model is a plain word array plus expected read data, the
// error flag, the access counts and the number of clear cycles remaining.
// The model's clear tracking is set to 16 at every reset.
// Counter expectations follow the DMEM_STATS_EN build macro.
// ============================================================================
module tb_toy_dmem_responder;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        CLK;
  logic        RSTN;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        BUSY;
  logic        ERR;
  logic [15:0] RD_CNT;
  logic [15:0] WR_CNT;

  toy_dmem_responder #(.AW(AW)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .DREQ   (DREQ),
    .DRW    (DRW),
    .DADDR  (DADDR),
    .DWDATA (DWDATA),
    .DRDATA (DRDATA),
    .BUSY   (BUSY),
    .ERR    (ERR),
    .RD_CNT (RD_CNT),
    .WR_CNT (WR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  int          m_rd;
  int          m_wr;
  int          init_left;

  int n_cmp;
  int n_bad;
  bit chk_en;
  bit stats_on;

  function automatic logic [15:0] exp_cnt(int v);
    return stats_on ? 16'(v) : 16'h0000;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".drdata"}, DRDATA, m_rdata);
    check({tag, ".busy"},   32'(BUSY), 32'(init_left > 0));
    check({tag, ".err"},    32'(ERR), 32'(m_err));
    check({tag, ".rd_cnt"}, 32'(RD_CNT), 32'(exp_cnt(m_rd)));
    check({tag, ".wr_cnt"}, 32'(WR_CNT), 32'(exp_cnt(m_wr)));
  endtask

  // One clock cycle with the given request; the model is advanced using the
  // state as it was before the edge.
  task automatic access(input bit req, input bit rw, input logic [29:0] a,
                        input logic [31:0] d, input string tag);
    DREQ   = req;
    DRW    = rw;
    DADDR  = a;
    DWDATA = d;
    @(posedge CLK);
    if (req) begin
      if (init_left > 0) begin
        m_err = 1'b1;
      end else if (a >= 30'(DEPTH)) begin
        m_err = 1'b1;
        if (!rw) m_rdata = 32'h0;
      end else if (rw) begin
        m_mem[a[3:0]] = d;
        if (m_wr < 65535) m_wr++;
      end else begin
        m_rdata = m_mem[a[3:0]];
        if (m_rd < 65535) m_rd++;
      end
    end
    if (init_left > 0) init_left--;
    #1;
    DREQ = 1'b0;
    if (chk_en) check_all(tag);
  endtask

  // Asserts reset from the current time, checks asynchronous reset values,
  // and releases reset 1 time unit after a rising edge.
  task automatic do_reset(input string tag);
    RSTN = 1'b0;
    DREQ = 1'b0;
    DRW  = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_rdata   = 32'h0;
    m_err     = 1'b0;
    m_rd      = 0;
    m_wr      = 0;
    init_left = DEPTH;
    #1;
    check_all({tag, ".async"});
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
  endtask

  // Counts edges until BUSY falls (bounded); started_at = edges already used.
  task automatic wait_ready(input int started_at, input string tag);
    int cnt;
    cnt = started_at;
    while (BUSY === 1'b1 && cnt < 100) begin
      access(1'b0, 1'b0, 30'h0, 32'h0, {tag, ".init"});
      cnt++;
    end
    check({tag, ".busy_edges"}, 32'(cnt), 32'd16);
  endtask

  initial begin
    logic [29:0] a;
    n_cmp    = 0;
    n_bad    = 0;
    chk_en   = 1'b1;
`ifdef DMEM_STATS_EN
    stats_on = 1'b1;
`else
    stats_on = 1'b0;
`endif
    RSTN   = 1'b0;
    DREQ   = 1'b0;
    DRW    = 1'b0;
    DADDR  = '0;
    DWDATA = '0;

    // Reset clear and read-back of a zeroed array
    do_reset("t1");
    wait_ready(0, "t1");
    for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b0, 30'(i), 32'h0, "t1.rd");
    check("t1.err_clean", 32'(ERR), 32'd0);

    // Write then read latency and hold behaviour
    access(1'b1, 1'b1, 30'd5, 32'hDEADBEEF, "t2.wr");
    check("t2.wr_edge", DRDATA, 32'h0);
    access(1'b1, 1'b0, 30'd5, 32'h0, "t2.rd");
    check("t2.rd_data", DRDATA, 32'hDEADBEEF);
    repeat (3) access(1'b0, 1'b0, 30'd5, 32'h0, "t2.hold");
    check("t2.held", DRDATA, 32'hDEADBEEF);

    // Out-of-range accesses
    access(1'b1, 1'b1, 30'h10, 32'h1234, "t3.oor_wr");
    check("t3.err", 32'(ERR), 32'd1);
    access(1'b1, 1'b0, 30'd0, 32'h0, "t3.rd0");
    check("t3.addr0", DRDATA, 32'h0);
    access(1'b1, 1'b0, 30'd5, 32'h0, "t3.rd5");
    access(1'b1, 1'b0, 30'h3FFFFFFF, 32'h0, "t3.oor_rd");
    check("t3.oor_data", DRDATA, 32'h0);

    // Request during the clear
    do_reset("t4");
    access(1'b0, 1'b0, 30'h0, 32'h0, "t4.idle");
    access(1'b0, 1'b0, 30'h0, 32'h0, "t4.idle");
    access(1'b1, 1'b1, 30'd2, 32'hA5A5A5A5, "t4.busy_wr");
    check("t4.err", 32'(ERR), 32'd1);
    wait_ready(3, "t4");
    access(1'b1, 1'b0, 30'd2, 32'h0, "t4.rd2");
    check("t4.addr2", DRDATA, 32'h0);

    // Reset asserted mid-clear, between clock edges
    do_reset("t5a");
    access(1'b1, 1'b0, 30'd7, 32'h0, "t5.busy_rd");
    repeat (7) access(1'b0, 1'b0, 30'h0, 32'h0, "t5.idle");
    check("t5.err_before", 32'(ERR), 32'd1);
    #2;
    do_reset("t5b");
    wait_ready(0, "t5");

    // Statistics
    do_reset("t6");
    wait_ready(0, "t6");
    access(1'b1, 1'b0, 30'd1, 32'h0, "t6.rd");
    access(1'b1, 1'b1, 30'd4, 32'h11112222, "t6.wr");
    access(1'b1, 1'b0, 30'd2, 32'h0, "t6.rd");
    access(1'b1, 1'b0, 30'h20, 32'h0, "t6.oor");
    access(1'b1, 1'b1, 30'd9, 32'h33334444, "t6.wr");
    access(1'b1, 1'b0, 30'd4, 32'h0, "t6.rd");
    check("t6.rd_cnt", 32'(RD_CNT), stats_on ? 32'd3 : 32'd0);
    check("t6.wr_cnt", 32'(WR_CNT), stats_on ? 32'd2 : 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)      a = 30'($urandom) | 30'h10;
      else if ($urandom_range(0, 1) == 0) a = 30'($urandom_range(0, 3));
      else                                a = 30'($urandom_range(0, DEPTH - 1));
      access($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom, "rnd");
    end

    // Read counter saturation
    chk_en = 1'b0;
    for (int i = 0; i < 70000; i++) access(1'b1, 1'b0, 30'(i % DEPTH), 32'h0, "sat");
    chk_en = 1'b1;
    access(1'b1, 1'b0, 30'd3, 32'h0, "sat.last");
    check("t6.rd_sat", 32'(RD_CNT), stats_on ? 32'h0000FFFF : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
